// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes and datapath select codes.
package mc_pkg;

   localparam int WAIT_W = 8;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RCOMP   = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   // States that own the shared memory port and wait on mem_ready.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory state has waited for mem_ready and flags a timeout at MAX_WAIT.
module mem_wait_timer
   import mc_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   input  logic ready,
   output logic timeout
);

   logic [WAIT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset || clear || ready)
         cnt <= '0;
      else if (tick)
         cnt <= cnt + 1'b1;
   end

   // A ready arriving on the limit cycle still wins.
   assign timeout = tick && !ready && (cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       bus_error
);

   state_t cur, nxt;
   logic   tmo, done_c, ill_c;
   logic   unused_zero;

   // Zero only qualifies PCWriteCond inside the datapath.
   assign unused_zero = Zero;
   assign state       = cur;

   always_ff @(posedge clk) begin
      if (!reset) cur <= S_FETCH;
      else        cur <= nxt;
   end

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   ((nxt != cur) || tmo),
      .tick    (is_mem_state(cur)),
      .ready   (mem_ready),
      .timeout (tmo)
   );

   always_comb begin
      nxt         = cur;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCS_ALU;
      done_c      = 1'b0;
      ill_c       = 1'b0;
      case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            // A fetch held in reset cannot reach DECODE, so it must not load IR/PC.
            if (mem_ready) begin
               IRWrite = reset;
               PCWrite = reset;
               nxt     = S_DECODE;
            end else if (tmo) begin
               nxt = S_FETCH;
            end
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            case (Op)
               OP_LW, OP_SW: nxt = S_MEMADDR;
               OP_RTYPE:     nxt = S_EXEC;
               OP_BEQ:       nxt = S_BRANCH;
               OP_J:         nxt = S_JUMP;
               OP_ADDI:      nxt = S_ADDIEX;
               default: begin
                  ill_c = 1'b1;
                  nxt   = S_FETCH;
               end
            endcase
         end
         S_MEMADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            nxt     = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready)  nxt = S_MEMWB;
            else if (tmo)   nxt = S_FETCH;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            done_c   = 1'b1;
            nxt      = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               done_c = 1'b1;
               nxt    = S_FETCH;
            end else if (tmo) begin
               nxt = S_FETCH;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
            nxt     = S_RCOMP;
         end
         S_RCOMP: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            done_c   = 1'b1;
            nxt      = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCS_ALUOUT;
            done_c      = 1'b1;
            nxt         = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCS_JUMP;
            done_c   = 1'b1;
            nxt      = S_FETCH;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADDI;
            nxt     = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
            done_c   = 1'b1;
            nxt      = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase
   end

   // Status pulses report instruction outcomes, and none resolves while reset holds the FSM.
   assign instr_done = done_c & reset;
   assign illegal_op = ill_c & reset;
   assign bus_error  = tmo & reset;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench: a timeline model plans states and outcomes per instruction; a monitor checks them.
module tb_mc_control_fsm;

   localparam int MW = 3;
   localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
   localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;

   logic clk = 1'b0, reset = 1'b0;
   logic [5:0] Op = '0;
   logic Zero = 1'b0, mem_ready = 1'b0;
   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
   logic instr_done, illegal_op, bus_error;

   mc_control_fsm #(.MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .state(state), .instr_done(instr_done),
      .illegal_op(illegal_op), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] kind;   // {instr_done, illegal_op, bus_error}
      int len, ir, pcw, pcc, rw, mwr, m2r, rd;
   } out_t;
   typedef struct packed { logic [5:0] op; logic rdy; } drv_t;

   drv_t drv_q[$];
   int   st_q[$];
   out_t out_q[$];
   int   checks = 0, failures = 0, plen = 0;
   bit   run = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int st, input logic [5:0] op, input logic rdy);
      drv_q.push_back('{op: op, rdy: rdy});
      st_q.push_back(st);
      plen++;
   endtask

   // A memory access: w low cycles then ready, or abort after MW+1 cycles if w exceeds MW.
   task automatic mem_phase(input int st, input logic [5:0] op, input int w, output bit ok);
      if (w > MW) begin
         repeat (MW + 1) cyc(st, op, 1'b0);
         ok = 1'b0;
      end else begin
         repeat (w) cyc(st, op, 1'b0);
         cyc(st, op, 1'b1);
         ok = 1'b1;
      end
   endtask

   task automatic plan(input logic [5:0] op, input int fw, input int mw);
      out_t e;
      bit ok;
      e = '0;
      plen = 0;
      mem_phase(0, op, fw, ok);
      if (!ok) e.kind = 3'b001;
      else begin
         e.ir = 1; e.pcw = 1; e.kind = 3'b100;
         cyc(1, op, 1'($urandom_range(0, 1)));
         case (op)
            T_R:    begin cyc(6, op, 1'($urandom_range(0, 1))); cyc(7, op, 1'($urandom_range(0, 1))); e.rw = 1; e.rd = 1; end
            T_LW: begin
               cyc(2, op, 1'($urandom_range(0, 1)));
               mem_phase(3, op, mw, ok);
               if (ok) begin cyc(4, op, 1'($urandom_range(0, 1))); e.rw = 1; e.m2r = 1; end
               else e.kind = 3'b001;
            end
            T_SW: begin
               cyc(2, op, 1'($urandom_range(0, 1)));
               mem_phase(5, op, mw, ok);
               if (ok) e.mwr = 1; else e.kind = 3'b001;
            end
            T_BEQ:  begin cyc(8, op, 1'($urandom_range(0, 1))); e.pcc = 1; end
            T_J:    begin cyc(9, op, 1'($urandom_range(0, 1))); e.pcw = 2; end
            T_ADDI: begin cyc(10, op, 1'($urandom_range(0, 1))); cyc(11, op, 1'($urandom_range(0, 1))); e.rw = 1; end
            default: e.kind = 3'b010;
         endcase
      end
      e.len = plen;
      out_q.push_back(e);
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] tbl [6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
      logic [5:0] r;
      int k = $urandom_range(0, 6);
      if (k < 6) return tbl[k];
      do r = 6'($urandom_range(0, 63));
      while (r == T_R || r == T_LW || r == T_SW || r == T_BEQ || r == T_J || r == T_ADDI);
      return r;
   endfunction

   function automatic int rand_wait();
      return ($urandom_range(0, 9) < 2) ? MW + 1 : int'($urandom_range(0, MW));
   endfunction

   // Monitor: per-cycle state check, per-instruction outcome check on any status pulse.
   initial begin
      out_t acc, e;
      acc = '0;
      forever begin
         @(negedge clk);
         if (run) begin
            if (st_q.size() == 0) chk("state_q_underrun", 1, 0);
            else chk("state", 32'(state), st_q.pop_front());
            acc.len++;
            acc.ir  += int'(IRWrite);
            acc.pcw += int'(PCWrite);
            acc.pcc += int'(PCWriteCond);
            acc.rw  += int'(RegWrite);
            acc.mwr += int'(MemWrite & mem_ready);
            acc.m2r += int'(RegWrite & MemtoReg);
            acc.rd  += int'(RegWrite & RegDst);
            if (IRWrite)
               chk("fetch_sel", {MemRead, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource}, {1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00});
            if (PCWriteCond)
               chk("branch_sel", {ALUSrcA, ALUSrcB, ALUOp, PCSource}, {1'b1, 2'b00, 2'b01, 2'b01});
            if (PCWrite && !IRWrite)
               chk("jump_sel", 32'(PCSource), 2'b10);
            if (MemWrite)
               chk("write_sel", {IorD, MemRead}, 2'b10);
            if (instr_done || illegal_op || bus_error) begin
               if (out_q.size() == 0) chk("outcome_q_underrun", 1, 0);
               else begin
                  e = out_q.pop_front();
                  chk("kind", {instr_done, illegal_op, bus_error}, e.kind);
                  chk("latency", acc.len, e.len);
                  chk("irwrite_cnt", acc.ir, e.ir);
                  chk("pcwrite_cnt", acc.pcw, e.pcw);
                  chk("pcwcond_cnt", acc.pcc, e.pcc);
                  chk("regwrite_cnt", acc.rw, e.rw);
                  chk("memwrite_cnt", acc.mwr, e.mwr);
                  chk("memtoreg_cnt", acc.m2r, e.m2r);
                  chk("regdst_cnt", acc.rd, e.rd);
               end
               acc = '0;
            end
         end
      end
   end

   initial begin
      drv_t d;
      reset = 1'b0; mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_state", 32'(state), 0);
         chk("reset_irwrite", 32'(IRWrite), 0);
         chk("reset_pcwrite", 32'(PCWrite), 0);
         chk("reset_pulses", {instr_done, illegal_op, bus_error}, 0);
      end

      plan(T_R, 0, 0);          // first post-reset cycle fetches
      plan(T_LW, 0, 2);
      plan(T_BEQ, 0, 0);
      plan(T_BEQ, 1, 0);
      plan(6'b111111, 0, 0);
      plan(T_SW, 0, MW + 1);    // write timeout
      plan(T_SW, 0, MW);        // ready on the limit cycle
      plan(T_LW, MW + 1, 0);    // fetch timeout
      plan(T_J, 2, 0);
      plan(T_ADDI, 0, 0);
      for (int i = 0; i < 200; i++) plan(rand_op(), rand_wait(), rand_wait());

      @(posedge clk); #1;
      reset = 1'b1;
      run = 1'b1;
      while (drv_q.size() != 0) begin
         d = drv_q.pop_front();
         Op = d.op;
         mem_ready = d.rdy;
         Zero = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      run = 1'b0;
      mem_ready = 1'b0;
      chk("outcomes_left", out_q.size(), 0);
      chk("states_left", st_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
